// File: rtl/vdp_pkg.sv
// ---------------------------------------------------------------------------
// vdp_pkg
// Shared VDP definitions: register-file address/data widths (used as the
// default widths by the register write arbiter and by the copper) and the
// encoding of the register write source flag.
// ---------------------------------------------------------------------------
package vdp_pkg;

   localparam int VDP_REG_ADDR_WIDTH = 6;
   localparam int VDP_REG_DATA_WIDTH = 16;

   localparam logic REG_SRC_HOST   = 1'b0;
   localparam logic REG_SRC_COPPER = 1'b1;

   // Width of an occupancy counter able to hold 0..depth inclusive.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/vdp_sync_fifo.sv
// ---------------------------------------------------------------------------
// vdp_sync_fifo
// Generic single-clock FIFO used for VDP buffering.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_data at the tail (caller must not push when full)
//   pop         : advance the head (caller must not pop when empty)
//   flush       : discard all contents on the next edge
//   push_data   : data to write
//   pop_data    : current head entry (combinational read of the head slot)
//   level       : occupancy, 0..DEPTH
//   full, empty : occupancy flags decoded from level
//
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module vdp_sync_fifo
   import vdp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             push_data,
   output logic [WIDTH-1:0]             pop_data,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                         full,
   output logic                         empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = level_width(DEPTH);
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Level is kept as its own counter so full and empty are unambiguous
   // even though the pointers are only log2(DEPTH) bits wide.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (level == DEPTH_L);
   assign empty    = (level == '0);

endmodule

// File: rtl/vdp_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// vdp_reg_write_arbiter
// Merges host CPU register writes and copper register writes into a single
// registered write stream to the VDP register file. The host never stalls
// and has strict priority; copper writes are buffered in a FIFO and drained
// whenever the host leaves the slot free.
//
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   copper_enable            : copper running; low flushes the copper FIFO
//   host_write_en/_address/_data     : host write, one strobe per write
//   copper_write_en/_address/_data   : copper write, accepted when ready
//   copper_write_ready       : FIFO can take a copper write this cycle
//   reg_write_en/_address/_data      : registered write to the register file
//   reg_write_source         : 0 = host, 1 = copper
//   copper_overflow          : sticky, a copper write arrived while not ready
//   fifo_level               : copper FIFO occupancy
// ---------------------------------------------------------------------------
module vdp_reg_write_arbiter
   import vdp_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = VDP_REG_ADDR_WIDTH,
   parameter int DATA_WIDTH = VDP_REG_DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          copper_enable,
   input  logic                          host_write_en,
   input  logic [ADDR_WIDTH-1:0]         host_write_address,
   input  logic [DATA_WIDTH-1:0]         host_write_data,
   input  logic                          copper_write_en,
   input  logic [ADDR_WIDTH-1:0]         copper_write_address,
   input  logic [DATA_WIDTH-1:0]         copper_write_data,
   output logic                          copper_write_ready,
   output logic                          reg_write_en,
   output logic [ADDR_WIDTH-1:0]         reg_write_address,
   output logic [DATA_WIDTH-1:0]         reg_write_data,
   output logic                          reg_write_source,
   output logic                          copper_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_flush;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_head;

   // Ready depends only on copper_enable and registered occupancy, so the
   // copper never sees a combinational path from its own strobe.
   assign copper_write_ready = copper_enable && !fifo_full;
   assign fifo_push          = copper_write_en && copper_write_ready && !reset;
   assign fifo_pop           = !host_write_en && !fifo_empty && !reset;
   // A pop in the flush cycle is still presented on the output registers;
   // only the entries left behind are discarded.
   assign fifo_flush         = !copper_enable;

   vdp_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) copper_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .push_data ({copper_write_address, copper_write_data}),
      .pop_data  (fifo_head),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Overflow is sticky while the copper runs; disabling the copper clears it.
   always_ff @(posedge clk) begin
      if (reset || !copper_enable) begin
         copper_overflow <= 1'b0;
      end else if (copper_write_en && !copper_write_ready) begin
         copper_overflow <= 1'b1;
      end
   end

   // Output slot: host first, then the copper FIFO head. When idle the
   // address/data/source hold their last values and only the strobe drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_en      <= 1'b0;
         reg_write_address <= '0;
         reg_write_data    <= '0;
         reg_write_source  <= REG_SRC_HOST;
      end else if (host_write_en) begin
         reg_write_en      <= 1'b1;
         reg_write_address <= host_write_address;
         reg_write_data    <= host_write_data;
         reg_write_source  <= REG_SRC_HOST;
      end else if (!fifo_empty) begin
         reg_write_en                        <= 1'b1;
         {reg_write_address, reg_write_data} <= fifo_head;
         reg_write_source                    <= REG_SRC_COPPER;
      end else begin
         reg_write_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vdp_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vdp_reg_write_arbiter
// Randomised and directed stimulus for vdp_reg_write_arbiter. A queue-based
// reference model pushes each expected register write into a scoreboard at
// the clock edge; an independent monitor pops and compares whenever the DUT
// presents (or should present) a write.
// ---------------------------------------------------------------------------
module tb_vdp_reg_write_arbiter;

   localparam int DEPTH = 4;
   localparam int AW    = 6;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          copper_enable;
   logic          host_write_en;
   logic [AW-1:0] host_write_address;
   logic [DW-1:0] host_write_data;
   logic          copper_write_en;
   logic [AW-1:0] copper_write_address;
   logic [DW-1:0] copper_write_data;
   logic          copper_write_ready;
   logic          reg_write_en;
   logic [AW-1:0] reg_write_address;
   logic [DW-1:0] reg_write_data;
   logic          reg_write_source;
   logic          copper_overflow;
   logic [$clog2(DEPTH):0] fifo_level;

   always #5 clk = ~clk;

   vdp_reg_write_arbiter #(
      .FIFO_DEPTH (DEPTH),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .copper_enable        (copper_enable),
      .host_write_en        (host_write_en),
      .host_write_address   (host_write_address),
      .host_write_data      (host_write_data),
      .copper_write_en      (copper_write_en),
      .copper_write_address (copper_write_address),
      .copper_write_data    (copper_write_data),
      .copper_write_ready   (copper_write_ready),
      .reg_write_en         (reg_write_en),
      .reg_write_address    (reg_write_address),
      .reg_write_data       (reg_write_data),
      .reg_write_source     (reg_write_source),
      .copper_overflow      (copper_overflow),
      .fifo_level           (fifo_level)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          s;
   } wr_t;

   wr_t  exp_q[$];      // scoreboard: writes expected on the output
   wr_t  cq[$];         // model of pending copper writes
   logic m_ovf = 1'b0;
   int   tests = 0;
   int   fails = 0;
   bit   mon_on = 1'b0;
   int   peak_level = 0;
   logic [AW-1:0] log_addr[$];
   logic          log_src[$];

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Reference model: a pending-write queue with capacity DEPTH. Each edge
   // the host claims the slot if present, otherwise the oldest pending copper
   // write goes out; a copper write joins the queue when there was room.
   always @(posedge clk) begin
      bit  rdy;
      wr_t w;
      if (reset) begin
         cq.delete();
         m_ovf = 1'b0;
      end else begin
         rdy = copper_enable && (cq.size() < DEPTH);
         if (host_write_en) begin
            w.a = host_write_address;
            w.d = host_write_data;
            w.s = 1'b0;
            exp_q.push_back(w);
         end else if (cq.size() > 0) begin
            exp_q.push_back(cq.pop_front());
         end
         if (copper_enable) begin
            if (copper_write_en) begin
               if (rdy) begin
                  w.a = copper_write_address;
                  w.d = copper_write_data;
                  w.s = 1'b1;
                  cq.push_back(w);
               end else begin
                  m_ovf = 1'b1;
               end
            end
         end else begin
            cq.delete();
            m_ovf = 1'b0;
         end
      end
   end

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      wr_t w;
      if (mon_on) begin
         check("fifo_level", 32'(fifo_level), 32'(cq.size()));
         check("copper_write_ready", 32'(copper_write_ready),
               32'(copper_enable && (cq.size() < DEPTH)));
         check("copper_overflow", 32'(copper_overflow), 32'(m_ovf));
         if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
         tests++;
         if (reg_write_en === 1'b1) begin
            log_addr.push_back(reg_write_address);
            log_src.push_back(reg_write_source);
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_write: actual addr %0h data %0h src %0b, required no write (t=%0t)",
                        reg_write_address, reg_write_data, reg_write_source, $time);
            end else begin
               w = exp_q.pop_front();
               if ({reg_write_address, reg_write_data, reg_write_source} !== {w.a, w.d, w.s}) begin
                  fails++;
                  $display("FAIL write_content: actual addr %0h data %0h src %0b, required addr %0h data %0h src %0b (t=%0t)",
                           reg_write_address, reg_write_data, reg_write_source, w.a, w.d, w.s, $time);
               end
            end
         end else if (exp_q.size() > 0 || reg_write_en !== 1'b0) begin
            fails++;
            if (exp_q.size() > 0) begin
               w = exp_q.pop_front();
               $display("FAIL missing_write: actual reg_write_en %b, required write addr %0h data %0h src %0b (t=%0t)",
                        reg_write_en, w.a, w.d, w.s, $time);
            end else begin
               $display("FAIL reg_write_en: actual %b, required 0 (t=%0t)", reg_write_en, $time);
            end
         end
      end
   end

   task automatic drive(input logic hwe, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                        input logic cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
      host_write_en        = hwe;
      host_write_address   = ha;
      host_write_data      = hd;
      copper_write_en      = cwe;
      copper_write_address = ca;
      copper_write_data    = cd;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_src.delete();
   endtask

   // Collects the addresses of copper-sourced writes seen since clear_log.
   task automatic copper_addrs(output logic [AW-1:0] q[$]);
      q.delete();
      for (int i = 0; i < log_addr.size(); i++)
         if (log_src[i] === 1'b1) q.push_back(log_addr[i]);
   endtask

   initial begin
      logic [AW-1:0] cop[$];
      logic [AW-1:0] pushed[$];
      int            n;
      int            cyc;
      logic [AW-1:0] exp_burst[5];
      logic          hw;
      logic          cw;

      reset                = 1'b1;
      copper_enable        = 1'b1;
      host_write_en        = 1'b0;
      host_write_address   = '0;
      host_write_data      = '0;
      copper_write_en      = 1'b0;
      copper_write_address = '0;
      copper_write_data    = '0;
      mon_on               = 1'b1;

      // Reset held for two cycles with random inputs.
      for (int i = 0; i < 2; i++) begin
         copper_enable = 1'($urandom);
         drive(1'($urandom), AW'($urandom), DW'($urandom),
               1'($urandom), AW'($urandom), DW'($urandom));
      end
      check("rst_reg_write_en", 32'(reg_write_en), 32'd0);
      check("rst_reg_write_address", 32'(reg_write_address), 32'd0);
      check("rst_reg_write_data", 32'(reg_write_data), 32'd0);
      check("rst_reg_write_source", 32'(reg_write_source), 32'd0);
      check("rst_fifo_level", 32'(fifo_level), 32'd0);
      check("rst_copper_overflow", 32'(copper_overflow), 32'd0);
      reset         = 1'b0;
      copper_enable = 1'b1;
      idle(2);

      // Host only: two back-to-back writes.
      clear_log();
      drive(1'b1, 6'h05, 16'h1234, 1'b0, '0, '0);
      drive(1'b1, 6'h06, 16'hABCD, 1'b0, '0, '0);
      idle(2);
      check("host_count", 32'(log_addr.size()), 32'd2);
      if (log_addr.size() == 2) begin
         check("host_order0", 32'(log_addr[0]), 32'h05);
         check("host_order1", 32'(log_addr[1]), 32'h06);
      end

      // Copper burst with a host write arriving the cycle after the second push.
      clear_log();
      peak_level = 0;
      drive(1'b0, '0, '0, 1'b1, 6'h10, 16'h0000);
      drive(1'b0, '0, '0, 1'b1, 6'h11, 16'h0001);
      drive(1'b1, 6'h20, 16'hFFFF, 1'b1, 6'h12, 16'h0002);
      drive(1'b0, '0, '0, 1'b1, 6'h13, 16'h0003);
      idle(5);
      exp_burst[0] = 6'h10; exp_burst[1] = 6'h20; exp_burst[2] = 6'h11;
      exp_burst[3] = 6'h12; exp_burst[4] = 6'h13;
      check("burst_count", 32'(log_addr.size()), 32'd5);
      for (int i = 0; i < 5 && i < log_addr.size(); i++)
         check("burst_order", 32'(log_addr[i]), 32'(exp_burst[i]));
      check("burst_peak_level", 32'(peak_level), 32'd2);

      // Full and overflow: host holds the slot while the copper pushes five.
      clear_log();
      for (int i = 0; i < 5; i++) begin
         if (i == 4) check("full_ready_low", 32'(copper_write_ready), 32'd0);
         drive(1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'(6'h30 + i), DW'(i));
      end
      check("full_overflow", 32'(copper_overflow), 32'd1);
      idle(6);
      copper_addrs(cop);
      check("drain_count", 32'(cop.size()), 32'd4);
      for (int i = 0; i < 4 && i < cop.size(); i++)
         check("drain_order", 32'(cop[i]), 32'(6'h30 + i));

      // Flush: three writes pending, copper disabled for one cycle.
      for (int i = 0; i < 3; i++)
         drive(1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'(6'h38 + i), DW'(i));
      check("flush_pre_level", 32'(fifo_level), 32'd3);
      clear_log();
      copper_enable = 1'b0;
      drive(1'b1, 6'h3F, 16'h5555, 1'b0, '0, '0);
      copper_enable = 1'b1;
      check("flush_level", 32'(fifo_level), 32'd0);
      check("flush_overflow", 32'(copper_overflow), 32'd0);
      idle(5);
      copper_addrs(cop);
      check("flush_no_copper", 32'(cop.size()), 32'd0);

      // Wrap-around: 3*DEPTH accepted pushes honouring ready, random host.
      clear_log();
      pushed.delete();
      n   = 0;
      cyc = 0;
      while (n < 3 * DEPTH && cyc < 500) begin
         hw = ($urandom_range(0, 1) == 0);
         cw = copper_write_ready && ($urandom_range(0, 3) != 0);
         if (cw) begin
            copper_write_address = AW'($urandom);
            pushed.push_back(copper_write_address);
            n++;
         end
         drive(hw, AW'($urandom), DW'($urandom), cw,
               cw ? pushed[pushed.size()-1] : AW'(0), DW'($urandom));
         cyc++;
      end
      check("wrap_pushes_done", 32'(n), 32'(3 * DEPTH));
      idle(3 * DEPTH + 4);
      copper_addrs(cop);
      check("wrap_count", 32'(cop.size()), 32'(pushed.size()));
      for (int i = 0; i < pushed.size() && i < cop.size(); i++)
         check("wrap_order", 32'(cop[i]), 32'(pushed[i]));
      check("wrap_no_overflow", 32'(copper_overflow), 32'd0);

      // Random soak including disables, resets and writes while not ready.
      for (int i = 0; i < 400; i++) begin
         reset         = ($urandom_range(0, 49) == 0);
         copper_enable = ($urandom_range(0, 9) != 0);
         drive(($urandom_range(0, 9) < 3), AW'($urandom), DW'($urandom),
               1'($urandom), AW'($urandom), DW'($urandom));
      end
      reset         = 1'b0;
      copper_enable = 1'b1;
      idle(DEPTH + 4);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
